// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller time-sharing one full-adder cell

// One-bit full-adder cell; the only arithmetic in the datapath.
module serial_adder_fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

// Start/busy/done controller feeding operand bits LSB first through the cell.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // A one-bit operand still needs a one-bit counter so the port widths stay legal.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             cell_s;
   logic             cell_co;
   logic             accept;
   logic             last_bit;

   serial_adder_fa_cell u_cell (
      .a  (op_a[0]),
      .b  (op_b[0]),
      .c  (carry),
      .s  (cell_s),
      .co (cell_co)
   );

   // Start is only honoured when no operation is in flight.
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last_bit = (cnt == LAST);

   // Next accumulator value: shift right, this cycle's sum bit enters at the MSB.
   // Written as shift/or so it stays valid for WIDTH == 1.
   always_comb begin
      acc_next = (acc >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
   end

   // Status outputs are pure decodes of the registered state.
   assign busy = (state == ADD);
   assign done = (state == DONE);

   // Sequencer and datapath registers; sum/cout are only written on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= ADD;
               end else begin
                  state <= IDLE;
               end
            end
            ADD: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               carry <= cell_co;
               acc   <= acc_next;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  sum   <= acc_next;
                  cout  <= cell_co;
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH 8, 1 and 13
module tb_serial_adder_ctrl;

   logic clk;
   logic rst;

   logic        start8, busy8, done8, cin8, cout8;
   logic [7:0]  a8, b8, sum8;
   logic        start1, busy1, done1, cin1, cout1;
   logic [0:0]  a1, b1, sum1;
   logic        start13, busy13, done13, cin13, cout13;
   logic [12:0] a13, b13, sum13;

   logic [8:0]  q8[$];
   logic [1:0]  q1[$];
   logic [13:0] q13[$];

   int checks;
   int errors;

   serial_adder_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   serial_adder_ctrl #(.WIDTH(13)) u13 (
      .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
      .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest queued expectation.
   task automatic mon();
      logic [8:0]  e8;
      logic [1:0]  e1;
      logic [13:0] e13;
      if (done8) begin
         chk("done8_has_expectation", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) begin
            e8 = q8.pop_front();
            chk("res8", 32'({cout8, sum8}), 32'(e8));
         end
      end
      if (done1) begin
         chk("done1_has_expectation", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            e1 = q1.pop_front();
            chk("res1", 32'({cout1, sum1}), 32'(e1));
         end
      end
      if (done13) begin
         chk("done13_has_expectation", 32'(q13.size() != 0), 32'd1);
         if (q13.size() != 0) begin
            e13 = q13.pop_front();
            chk("res13", 32'({cout13, sum13}), 32'(e13));
         end
      end
   endtask

   // Advance one cycle: monitor at the falling edge, then land 1 time unit after the rising edge.
   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
      int n;
      start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
      q8.push_back(9'(ta) + 9'(tb) + 9'(tc));
      step();
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 40) begin
         chk("busy8_during_add", 32'(busy8), 32'd1);
         step();
         n++;
      end
      chk("lat8", 32'(n), 32'd8);
      chk("busy8_in_done", 32'(busy8), 32'd0);
   endtask

   task automatic op1(input logic ta, input logic tb, input logic tc);
      int n;
      start1 = 1'b1; a1 = ta; b1 = tb; cin1 = tc;
      q1.push_back(2'(ta) + 2'(tb) + 2'(tc));
      step();
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 40) begin
         chk("busy1_during_add", 32'(busy1), 32'd1);
         step();
         n++;
      end
      chk("lat1", 32'(n), 32'd1);
   endtask

   initial begin
      int n;
      int pulses;
      checks = 0; errors = 0;
      rst = 1'b1;
      start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
      start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
      start13 = 0; a13 = '0; b13 = '0; cin13 = 0;
      @(posedge clk); #1;
      step(); step();

      // Reset state, with start asserted to show reset wins.
      start8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
      step();
      start8 = 1'b0;
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
      chk("rst_sum8", 32'(sum8), 32'd0);
      chk("rst_cout8", 32'(cout8), 32'd0);
      chk("rst_sum13", 32'(sum13), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      rst = 1'b0;
      step();

      // Basic add and hold of the result.
      op8(8'h0F, 8'h01, 1'b0);
      step(); step(); step();
      chk("sum8_held", 32'(sum8), 32'h10);
      chk("cout8_held", 32'(cout8), 32'd0);
      chk("q8_drained", 32'(q8.size()), 32'd0);

      // Full carry ripple cases.
      op8(8'hFF, 8'h01, 1'b0);
      step();
      op8(8'hFF, 8'hFF, 1'b1);
      step();
      op8(8'h00, 8'h00, 1'b0);
      step();

      // Start held through ADD with changing operands, then a back-to-back start from DONE.
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
      q8.push_back(9'h046);
      step();
      for (int k = 0; k < 8; k++) begin
         chk("busy8_hold", 32'(busy8), 32'd1);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         step();
      end
      chk("done8_first_b2b", 32'(done8), 32'd1);
      a8 = 8'h20; b8 = 8'h22; cin8 = 1'b0;
      q8.push_back(9'h042);
      step();
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 40) begin
         step();
         n++;
      end
      chk("lat8_b2b", 32'(n), 32'd8);
      step();
      chk("q8_b2b_drained", 32'(q8.size()), 32'd0);

      // Reset in the middle of an add: abandoned, no done pulse, outputs cleared.
      start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
      q8.push_back(9'h010);
      step();
      start8 = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      chk("midrst_busy8", 32'(busy8), 32'd0);
      chk("midrst_done8", 32'(done8), 32'd0);
      chk("midrst_sum8", 32'(sum8), 32'd0);
      chk("midrst_cout8", 32'(cout8), 32'd0);
      q8.delete();
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
         pulses += int'(done8);
         step();
      end
      chk("midrst_no_done", 32'(pulses), 32'd0);
      op8(8'h3C, 8'hC3, 1'b1);
      step();

      // Single-bit instance.
      op1(1'b1, 1'b1, 1'b1);
      step();
      op1(1'b1, 1'b0, 1'b0);
      step();
      op1(1'b0, 1'b0, 1'b0);
      step();

      // Random operands on all three widths in parallel.
      for (int i = 0; i < 1000; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
         a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
         q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
         q1.push_back(2'(a1) + 2'(b1) + 2'(cin1));
         q13.push_back(14'(a13) + 14'(b13) + 14'(cin13));
         start8 = 1'b1; start1 = 1'b1; start13 = 1'b1;
         step();
         start8 = 1'b0; start1 = 1'b0; start13 = 1'b0;
         n = 0;
         while ((q8.size() + q1.size() + q13.size()) != 0 && n < 40) begin
            step();
            n++;
         end
         chk("rand_timeout", 32'(n < 40), 32'd1);
      end

      step(); step();
      chk("final_q8_empty", 32'(q8.size()), 32'd0);
      chk("final_q13_empty", 32'(q13.size()), 32'd0);
      chk("final_q1_empty", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
